// File: rtl/pipelined_memory.sv
// Word-addressed synchronous RAM with a request/response handshake, per-byte
// write enables, a READ_LATENCY-deep response pipeline and in-order error responses.
module pipelined_memory #(
  parameter int WORD_SIZE    = 32,
  parameter int MEMORY_SIZE  = 1000,
  parameter int READ_LATENCY = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   ready,
  input  logic                   write_enabled,
  input  logic [WORD_SIZE-1:0]   address,
  input  logic [WORD_SIZE-1:0]   input_data,
  input  logic [WORD_SIZE/8-1:0] byte_enable,
  output logic                   valid,
  input  logic                   resp_ready,
  output logic [WORD_SIZE-1:0]   output_data,
  output logic                   resp_write,
  output logic                   err_invalid_address
);

  localparam int BYTES      = WORD_SIZE / 8;
  localparam int INDEX_BITS = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam int LAST       = READ_LATENCY - 1;
  // One extra bit so that MEMORY_SIZE itself is representable.
  localparam logic [WORD_SIZE:0] MEM_LIMIT = (WORD_SIZE + 1)'(MEMORY_SIZE);

  logic [WORD_SIZE-1:0] mem [MEMORY_SIZE];

  logic [READ_LATENCY-1:0] stage_valid;
  logic [READ_LATENCY-1:0] stage_write;
  logic [READ_LATENCY-1:0] stage_err;
  logic [WORD_SIZE-1:0]    stage_data [READ_LATENCY];

  logic                  stall;
  logic                  accept;
  logic                  in_range;
  logic [INDEX_BITS-1:0] index;
  logic [WORD_SIZE-1:0]  read_word;
  logic [WORD_SIZE-1:0]  capture_data;

  assign in_range     = ({1'b0, address} < MEM_LIMIT);
  assign index        = address[INDEX_BITS-1:0];
  assign read_word    = mem[index];
  assign capture_data = (start && !write_enabled && in_range) ? read_word : '0;

  assign valid  = stage_valid[LAST];
  assign stall  = valid && !resp_ready;
  assign ready  = !stall;
  assign accept = start && ready;

  assign output_data         = valid ? stage_data[LAST] : '0;
  assign resp_write          = valid && stage_write[LAST];
  assign err_invalid_address = valid && stage_err[LAST];

  // The whole pipeline moves as one unit; a stalled response freezes every stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid <= '0;
      stage_write <= '0;
      stage_err   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_data[i] <= '0;
      end
    end else if (!stall) begin
      for (int i = 1; i < READ_LATENCY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_write[i] <= stage_write[i-1];
        stage_err[i]   <= stage_err[i-1];
        stage_data[i]  <= stage_data[i-1];
      end
      stage_valid[0] <= start;
      stage_write[0] <= start && write_enabled;
      stage_err[0]   <= start && !in_range;
      stage_data[0]  <= capture_data;
    end
  end

  // Array contents survive reset; only accepted in-range writes touch them.
  always_ff @(posedge clock) begin
    if (accept && write_enabled && in_range) begin
      for (int b = 0; b < BYTES; b++) begin
        if (byte_enable[b]) begin
          mem[index][8*b +: 8] <= input_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_memory.sv
// Randomised, self-checking bench for pipelined_memory: three instances with
// READ_LATENCY 2, 1 and 4 are checked against a transaction-level model.
module tb_pipelined_memory;

  localparam int N = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start_s      [N];
  logic        write_s      [N];
  logic [31:0] addr_s       [N];
  logic [31:0] wdata_s      [N];
  logic [3:0]  be_s         [N];
  logic        rr_s         [N];
  logic        ready_s      [N];
  logic        valid_s      [N];
  logic        resp_write_s [N];
  logic        err_s        [N];
  logic [31:0] rdata_s      [N];

  int errors = 0;
  int checks = 0;
  int cur    = 0;

  // An in-flight request: remaining counts unstalled edges until it is visible.
  typedef struct {
    int          remaining;
    bit          wr;
    bit          err;
    bit          known;
    logic [31:0] data;
  } item_t;

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } req_t;

  item_t       inflight [$];
  req_t        req_q [$];
  logic [31:0] model_mem [int];

  pipelined_memory #(.WORD_SIZE(32), .MEMORY_SIZE(1000), .READ_LATENCY(2)) u_lat2 (
    .clock(clock), .reset_n(reset_n), .start(start_s[0]), .ready(ready_s[0]),
    .write_enabled(write_s[0]), .address(addr_s[0]), .input_data(wdata_s[0]),
    .byte_enable(be_s[0]), .valid(valid_s[0]), .resp_ready(rr_s[0]),
    .output_data(rdata_s[0]), .resp_write(resp_write_s[0]), .err_invalid_address(err_s[0])
  );

  pipelined_memory #(.WORD_SIZE(32), .MEMORY_SIZE(1000), .READ_LATENCY(1)) u_lat1 (
    .clock(clock), .reset_n(reset_n), .start(start_s[1]), .ready(ready_s[1]),
    .write_enabled(write_s[1]), .address(addr_s[1]), .input_data(wdata_s[1]),
    .byte_enable(be_s[1]), .valid(valid_s[1]), .resp_ready(rr_s[1]),
    .output_data(rdata_s[1]), .resp_write(resp_write_s[1]), .err_invalid_address(err_s[1])
  );

  pipelined_memory #(.WORD_SIZE(32), .MEMORY_SIZE(1000), .READ_LATENCY(4)) u_lat4 (
    .clock(clock), .reset_n(reset_n), .start(start_s[2]), .ready(ready_s[2]),
    .write_enabled(write_s[2]), .address(addr_s[2]), .input_data(wdata_s[2]),
    .byte_enable(be_s[2]), .valid(valid_s[2]), .resp_ready(rr_s[2]),
    .output_data(rdata_s[2]), .resp_write(resp_write_s[2]), .err_invalid_address(err_s[2])
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic bit exp_valid();
    return (inflight.size() > 0) && (inflight[0].remaining == 0);
  endfunction

  function automatic bit model_ready();
    return !(exp_valid() && !rr_s[cur]);
  endfunction

  task automatic drive(input int k, input bit st, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input bit rr);
    cur = k;
    for (int i = 0; i < N; i++) begin
      start_s[i] = 1'b0; write_s[i] = 1'b0; addr_s[i] = '0;
      wdata_s[i] = '0;   be_s[i]    = '0;   rr_s[i]   = 1'b1;
    end
    start_s[k] = st; write_s[k] = we; addr_s[k] = a;
    wdata_s[k] = d;  be_s[k]    = be; rr_s[k]   = rr;
  endtask

  task automatic push_req(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    req_t r;
    r.we = we; r.a = a; r.d = d; r.be = be;
    req_q.push_back(r);
  endtask

  // Presents the oldest pending request (or a bubble); it leaves the queue once accepted.
  task automatic issue_step(input int k, input bit rr);
    if (req_q.size() > 0) begin
      drive(k, 1'b1, req_q[0].we, req_q[0].a, req_q[0].d, req_q[0].be, rr);
      if (model_ready()) void'(req_q.pop_front());
    end else begin
      drive(k, 1'b0, 1'b0, '0, '0, '0, rr);
    end
  endtask

  // Advances one clock edge and applies the memory/response rules to the model.
  task automatic tick();
    bit          stall;
    item_t       it;
    int          key;
    logic [31:0] merged;
    stall = !model_ready();
    @(posedge clock);
    if (reset_n && !stall) begin
      if (exp_valid()) void'(inflight.pop_front());
      foreach (inflight[i]) begin
        if (inflight[i].remaining > 0) inflight[i].remaining = inflight[i].remaining - 1;
      end
      if (start_s[cur]) begin
        it.remaining = lat_of(cur) - 1;
        it.wr        = write_s[cur];
        it.err       = (addr_s[cur] >= 32'd1000);
        it.known     = 1'b1;
        it.data      = '0;
        if (!it.err) begin
          key = cur * 1000 + int'(addr_s[cur]);
          if (it.wr) begin
            if (be_s[cur] == 4'hF) begin
              model_mem[key] = wdata_s[cur];
            end else if (model_mem.exists(key)) begin
              merged = model_mem[key];
              for (int b = 0; b < 4; b++) if (be_s[cur][b]) merged[8*b +: 8] = wdata_s[cur][8*b +: 8];
              model_mem[key] = merged;
            end
          end else begin
            it.known = model_mem.exists(key);
            it.data  = it.known ? model_mem[key] : 32'h0;
          end
        end
        inflight.push_back(it);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    reset_n = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({valid_s[k], resp_write_s[k], err_s[k]} !== 3'b000 || rdata_s[k] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_outputs inst=%0d: valid/wr/err=%b%b%b data=%h, want 000 and 0",
                 k, valid_s[k], resp_write_s[k], err_s[k], rdata_s[k]);
      end
    end
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (ready_s[k] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_ready inst=%0d: got %b want 1", k, ready_s[k]);
      end
    end
  endtask

  task automatic test_write_read();
    int  addrs [7] = '{0, 200, 400, 0, 200, 400, 100};
    int  first = -1;
    int  last  = -1;
    int  resp  = 0;
    bit  ev;
    push_req(1'b1, 32'd0,   32'h00000001, 4'hF);
    push_req(1'b1, 32'd200, 32'h000000C9, 4'hF);
    push_req(1'b1, 32'd400, 32'h00000191, 4'hF);
    for (int i = 3; i < 7; i++) push_req(1'b0, 32'(addrs[i]), $urandom, 4'hF);
    for (int c = 0; c < 40; c++) begin
      issue_step(0, 1'b1);
      tick();
      ev = exp_valid();
      checks++;
      if (valid_s[0] !== ev) begin
        errors++; $display("[TB] FAIL wr_rd_valid c=%0d: got %b want %b", c, valid_s[0], ev);
      end
      if (ev) begin
        if (first < 0) first = c;
        last = c;
        resp++;
        checks++;
        if ({resp_write_s[0], err_s[0]} !== {inflight[0].wr, inflight[0].err}) begin
          errors++; $display("[TB] FAIL wr_rd_kind c=%0d: wr/err got %b%b want %b%b", c,
                             resp_write_s[0], err_s[0], inflight[0].wr, inflight[0].err);
        end
        if (inflight[0].known) begin
          checks++;
          if (rdata_s[0] !== inflight[0].data) begin
            errors++; $display("[TB] FAIL wr_rd_data c=%0d: got %h want %h", c, rdata_s[0], inflight[0].data);
          end
        end
      end
      if (req_q.size() == 0 && inflight.size() == 0) break;
    end
    checks++;
    if (resp != 7 || (last - first + 1) != 7) begin
      errors++; $display("[TB] FAIL wr_rd_count: got %0d responses over %0d cycles, want 7 over 7",
                         resp, last - first + 1);
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] got [$];
    bit          ev;
    push_req(1'b1, 32'd999, 32'hFFFFFFFF, 4'hF);
    push_req(1'b1, 32'd999, 32'h12345678, 4'b0101);
    push_req(1'b0, 32'd999, '0, 4'hF);
    push_req(1'b1, 32'd999, $urandom, 4'b0000);
    push_req(1'b0, 32'd999, '0, 4'hF);
    push_req(1'b1, 32'd999, $urandom, 4'($urandom_range(0, 15)));
    push_req(1'b0, 32'd999, '0, 4'hF);
    for (int c = 0; c < 40; c++) begin
      issue_step(0, 1'b1);
      tick();
      ev = exp_valid();
      checks++;
      if (valid_s[0] !== ev) begin
        errors++; $display("[TB] FAIL be_valid c=%0d: got %b want %b", c, valid_s[0], ev);
      end
      if (ev) begin
        if (!inflight[0].wr) got.push_back(rdata_s[0]);
        checks++;
        if ({resp_write_s[0], err_s[0]} !== {inflight[0].wr, inflight[0].err} ||
            (inflight[0].known && rdata_s[0] !== inflight[0].data)) begin
          errors++; $display("[TB] FAIL be_resp c=%0d: wr/err=%b%b data=%h want %b%b %h", c,
                             resp_write_s[0], err_s[0], rdata_s[0],
                             inflight[0].wr, inflight[0].err, inflight[0].data);
        end
      end
      if (req_q.size() == 0 && inflight.size() == 0) break;
    end
    checks++;
    if (got.size() != 3) begin
      errors++; $display("[TB] FAIL be_count: got %0d reads want 3", got.size());
    end else begin
      checks++;
      if (got[0] !== 32'hFF34FF78 || got[1] !== 32'hFF34FF78) begin
        errors++; $display("[TB] FAIL be_merge: got %h/%h want FF34FF78/FF34FF78", got[0], got[1]);
      end
    end
  endtask

  task automatic test_invalid_address();
    int n_err = 0;
    bit ev;
    push_req(1'b1, 32'd1000,      $urandom, 4'hF);
    push_req(1'b0, 32'd1000,      '0,       4'hF);
    push_req(1'b1, 32'hFFFFFFFF,  $urandom, 4'hF);
    push_req(1'b0, 32'hFFFFFFFF,  '0,       4'hF);
    push_req(1'b0, 32'd999,       '0,       4'hF);
    for (int c = 0; c < 40; c++) begin
      issue_step(0, 1'b1);
      tick();
      ev = exp_valid();
      checks++;
      if (valid_s[0] !== ev) begin
        errors++; $display("[TB] FAIL inv_valid c=%0d: got %b want %b", c, valid_s[0], ev);
      end
      if (ev) begin
        if (err_s[0] === 1'b1) n_err++;
        checks++;
        if ({resp_write_s[0], err_s[0]} !== {inflight[0].wr, inflight[0].err} ||
            (inflight[0].known && rdata_s[0] !== inflight[0].data)) begin
          errors++; $display("[TB] FAIL inv_resp c=%0d: wr/err=%b%b data=%h want %b%b %h", c,
                             resp_write_s[0], err_s[0], rdata_s[0],
                             inflight[0].wr, inflight[0].err, inflight[0].data);
        end
      end
      if (req_q.size() == 0 && inflight.size() == 0) break;
    end
    checks++;
    if (n_err != 4 || inflight.size() != 0) begin
      errors++; $display("[TB] FAIL inv_count: got %0d error responses (%0d left) want 4 (0 left)",
                         n_err, inflight.size());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] addr [4];
    logic [31:0] data [4];
    logic [31:0] got  [$];
    int          hold_left  = 3;
    int          ready_lows = 0;
    bit          started    = 1'b0;
    bit          rr;
    bit          ev;
    for (int i = 0; i < 4; i++) begin
      addr[i] = 32'(20 + 50 * i + $urandom_range(0, 40));
      data[i] = $urandom;
      push_req(1'b1, addr[i], data[i], 4'hF);
    end
    for (int i = 0; i < 4; i++) push_req(1'b0, addr[i], '0, 4'hF);
    for (int c = 0; c < 60; c++) begin
      rr = !(started && hold_left > 0);
      if (!rr) hold_left--;
      issue_step(0, rr);
      #1;
      checks++;
      if (ready_s[0] !== model_ready()) begin
        errors++; $display("[TB] FAIL bp_ready c=%0d: got %b want %b", c, ready_s[0], model_ready());
      end
      if (ready_s[0] === 1'b0) ready_lows++;
      if (valid_s[0] === 1'b1 && rr && resp_write_s[0] === 1'b0) got.push_back(rdata_s[0]);
      tick();
      ev = exp_valid();
      if (ev && !inflight[0].wr) started = 1'b1;
      checks++;
      if (valid_s[0] !== ev) begin
        errors++; $display("[TB] FAIL bp_valid c=%0d: got %b want %b", c, valid_s[0], ev);
      end
      if (ev) begin
        checks++;
        if (resp_write_s[0] !== inflight[0].wr || rdata_s[0] !== inflight[0].data) begin
          errors++; $display("[TB] FAIL bp_hold c=%0d: wr=%b data=%h want %b %h", c,
                             resp_write_s[0], rdata_s[0], inflight[0].wr, inflight[0].data);
        end
      end
      if (req_q.size() == 0 && inflight.size() == 0) break;
    end
    checks++;
    if (ready_lows != 3 || got.size() != 4) begin
      errors++; $display("[TB] FAIL bp_counts: ready low %0d cycles, %0d reads; want 3 and 4",
                         ready_lows, got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== data[i]) begin
          errors++; $display("[TB] FAIL bp_order i=%0d: got %h want %h", i, got[i], data[i]);
        end
      end
    end
  endtask

  task automatic test_raw_latency();
    for (int k = 0; k < N; k++) begin
      logic [31:0] got [$];
      int          acc [$];
      int          lat;
      bit          is_rd;
      int          sz;
      bit          ev;
      logic [31:0] ra = 32'($urandom_range(0, 999));
      push_req(1'b1, 32'd7, 32'hA5A5A5A5, 4'hF);
      push_req(1'b0, 32'd7, '0, 4'hF);
      push_req(1'b1, ra, $urandom, 4'hF);
      push_req(1'b0, ra, '0, 4'hF);
      for (int c = 0; c < 40; c++) begin
        is_rd = (req_q.size() > 0) && !req_q[0].we;
        sz    = req_q.size();
        issue_step(k, 1'b1);
        if (is_rd && req_q.size() < sz) acc.push_back(c);
        tick();
        ev = exp_valid();
        checks++;
        if (valid_s[k] !== ev || (ev && (resp_write_s[k] !== inflight[0].wr ||
            (inflight[0].known && rdata_s[k] !== inflight[0].data)))) begin
          errors++; $display("[TB] FAIL raw_resp inst=%0d c=%0d: valid=%b wr=%b data=%h want %b", k, c,
                             valid_s[k], resp_write_s[k], rdata_s[k], ev);
        end
        if (valid_s[k] === 1'b1 && resp_write_s[k] === 1'b0) begin
          got.push_back(rdata_s[k]);
          lat = (acc.size() > 0) ? (c - acc.pop_front() + 1) : -1;
          checks++;
          if (lat != lat_of(k)) begin
            errors++; $display("[TB] FAIL raw_latency inst=%0d: got %0d want %0d", k, lat, lat_of(k));
          end
        end
        if (req_q.size() == 0 && inflight.size() == 0) break;
      end
      checks++;
      if (got.size() != 2 || got[0] !== 32'hA5A5A5A5) begin
        errors++; $display("[TB] FAIL raw_data inst=%0d: %0d reads, first %h, want 2 and A5A5A5A5",
                           k, got.size(), (got.size() > 0) ? got[0] : 32'h0);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] d = $urandom;
    logic [31:0] got [$];
    bit          ev;
    push_req(1'b0, 32'd10, '0, 4'hF);
    push_req(1'b1, 32'd50, d, 4'hF);
    issue_step(0, 1'b1);
    tick();
    issue_step(0, 1'b1);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    reset_n = 1'b0;
    inflight.delete();
    #1;
    checks++;
    if (valid_s[0] !== 1'b0 || rdata_s[0] !== 32'h0) begin
      errors++; $display("[TB] FAIL rst_drop: valid=%b data=%h want 0 and 0", valid_s[0], rdata_s[0]);
    end
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    push_req(1'b0, 32'd50, '0, 4'hF);
    for (int c = 0; c < 20; c++) begin
      if (c < 5) drive(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
      else issue_step(0, 1'b1);
      tick();
      ev = exp_valid();
      checks++;
      if (valid_s[0] !== ev) begin
        errors++; $display("[TB] FAIL rst_stale c=%0d: valid got %b want %b", c, valid_s[0], ev);
      end
      if (valid_s[0] === 1'b1) got.push_back(rdata_s[0]);
      if (c >= 5 && req_q.size() == 0 && inflight.size() == 0) break;
    end
    checks++;
    if (got.size() != 1 || got[0] !== d) begin
      errors++; $display("[TB] FAIL rst_commit: %0d responses, data %h, want 1 and %h",
                         got.size(), (got.size() > 0) ? got[0] : 32'h0, d);
    end
  endtask

  task automatic test_random();
    bit          ev;
    logic [31:0] a;
    for (int i = 0; i < 80; i++) begin
      a = ($urandom_range(0, 9) == 0) ? (32'd1000 + 32'($urandom_range(0, 3)) * 32'h3FFFFFFF)
                                      : 32'($urandom_range(0, 15));
      push_req($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)));
    end
    for (int c = 0; c < 500; c++) begin
      issue_step(0, $urandom_range(0, 3) != 0);
      tick();
      ev = exp_valid();
      checks++;
      if (valid_s[0] !== ev) begin
        errors++; $display("[TB] FAIL rnd_valid c=%0d: got %b want %b", c, valid_s[0], ev);
      end
      if (ev) begin
        checks++;
        if ({resp_write_s[0], err_s[0]} !== {inflight[0].wr, inflight[0].err} ||
            (inflight[0].known && rdata_s[0] !== inflight[0].data)) begin
          errors++; $display("[TB] FAIL rnd_resp c=%0d: wr/err=%b%b data=%h want %b%b %h", c,
                             resp_write_s[0], err_s[0], rdata_s[0],
                             inflight[0].wr, inflight[0].err, inflight[0].data);
        end
      end else begin
        checks++;
        if (rdata_s[0] !== 32'h0) begin
          errors++; $display("[TB] FAIL rnd_idle_data c=%0d: got %h want 0", c, rdata_s[0]);
        end
      end
      if (req_q.size() == 0 && inflight.size() == 0) break;
    end
    checks++;
    if (req_q.size() != 0 || inflight.size() != 0) begin
      errors++; $display("[TB] FAIL rnd_drain: %0d requests and %0d responses left, want 0",
                         req_q.size(), inflight.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_invalid_address();
    test_backpressure();
    test_raw_latency();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
